// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared AXI4-Lite responder types: response codes, clog2 and the window address decoder.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic        in_range;
    logic [31:0] index;
  } dec_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Offset wraps modulo 2^addr_w, so addresses below the base land far out of range.
  function automatic dec_t addr_decode(input logic [63:0] addr, input logic [63:0] base,
                                       input int unsigned addr_w, input int unsigned depth);
    logic [63:0] mask;
    logic [63:0] off;
    dec_t        d;
    mask       = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
    off        = (addr - base) & mask;
    d.in_range = off < (64'(depth) << 2);
    d.index    = off[33:2];
    return d;
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between an initiator (master) and axi_lite_mem_slave (slave).
interface axi_lite_mem_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,                 input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,                 output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_mem_slave_capture.sv
// One-entry valid/data capture register; accepts when empty and not held off.
module axi_lite_capture #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         hold,
  input  logic         clr,
  output logic         ready,
  output logic         full,
  output logic [W-1:0] data
);
  assign ready = ~full & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (in_valid && ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end
endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder over a small word memory with a local write notification.
// Define AXIL_SLV_WSTRB_EN to honour WSTRB byte enables; otherwise writes update whole words.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned                  C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                  C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                  C_MEM_DEPTH        = 16,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR       = '0
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  axi_lite_mem_slave_if.slave           s_axi,
  output logic                          wr_pulse,
  output logic [clog2(C_MEM_DEPTH)-1:0] wr_index
);
  localparam int unsigned IDX_W = clog2(C_MEM_DEPTH);
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB    = DW / 8;

  logic [DW-1:0]    mem [C_MEM_DEPTH];
  logic             aw_full, aw_rdy, w_full, w_rdy;
  logic [AW-1:0]    aw_addr;
  logic [DW-1:0]    w_data;
  logic [NB-1:0]    w_strb;
  logic             bvalid, rvalid, arready, commit, ar_hs;
  logic [1:0]       bresp, rresp;
  logic [DW-1:0]    rdata;
  dec_t             wdec, rdec;
  logic [IDX_W-1:0] w_idx, r_idx;

  logic unused_prot;
  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wdec.index, rdec.index};

  axi_lite_capture #(.W(AW)) u_aw (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(s_axi.S_AXI_AWVALID), .in_data(s_axi.S_AXI_AWADDR),
    .hold(bvalid), .clr(commit), .ready(aw_rdy), .full(aw_full), .data(aw_addr)
  );

  axi_lite_capture #(.W(DW + NB)) u_w (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .in_valid(s_axi.S_AXI_WVALID), .in_data({s_axi.S_AXI_WSTRB, s_axi.S_AXI_WDATA}),
    .hold(bvalid), .clr(commit), .ready(w_rdy), .full(w_full), .data({w_strb, w_data})
  );

  // READYs depend only on state and reset, never on the VALIDs.
  assign s_axi.S_AXI_AWREADY = S_AXI_ARESETN & aw_rdy;
  assign s_axi.S_AXI_WREADY  = S_AXI_ARESETN & w_rdy;
  assign arready             = S_AXI_ARESETN & ~rvalid;
  assign s_axi.S_AXI_ARREADY = arready;

  assign commit = aw_full & w_full & ~bvalid;
  assign ar_hs  = s_axi.S_AXI_ARVALID & arready;
  assign wdec   = addr_decode(64'(aw_addr), 64'(C_BASE_ADDR), AW, C_MEM_DEPTH);
  assign rdec   = addr_decode(64'(s_axi.S_AXI_ARADDR), 64'(C_BASE_ADDR), AW, C_MEM_DEPTH);
  assign w_idx  = wdec.index[IDX_W-1:0];
  assign r_idx  = rdec.index[IDX_W-1:0];

`ifndef AXIL_SLV_WSTRB_EN
  logic unused_strb;
  assign unused_strb = ^w_strb;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < int'(C_MEM_DEPTH); i++) mem[i] <= '0;
    end else if (commit && wdec.in_range) begin
`ifdef AXIL_SLV_WSTRB_EN
      for (int b = 0; b < int'(NB); b++)
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
`else
      mem[w_idx] <= w_data;
`endif
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= 1'b0;
      wr_index <= '0;
    end else begin
      wr_pulse <= commit & wdec.in_range;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wdec.in_range ? RESP_OKAY : RESP_SLVERR;
        if (wdec.in_range) wr_index <= w_idx;
      end else if (bvalid && s_axi.S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // mem is sampled before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= rdec.in_range ? RESP_OKAY : RESP_SLVERR;
      rdata  <= rdec.in_range ? mem[r_idx] : '0;
    end else if (rvalid && s_axi.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign s_axi.S_AXI_BVALID = bvalid;
  assign s_axi.S_AXI_BRESP  = bresp;
  assign s_axi.S_AXI_RVALID = rvalid;
  assign s_axi.S_AXI_RRESP  = rresp;
  assign s_axi.S_AXI_RDATA  = rdata;
endmodule
